// File: rtl/divider_pkg.sv
// divider_pkg: shared constants, channel-index width helper and the
// configuration-write record used by the clock_divider_bank slice.
// Optional feature macro used by this slice: DIVIDER_DUTY_OUT_EN.

package divider_pkg;

  // Default counter/period width and reset period for every channel.
  localparam int DIV_CNT_W      = 32;
  localparam int DIV_DEF_PERIOD = 5000;

  // Largest supported channel count; the write record's channel field is
  // sized for it.
  localparam int DIV_MAX_NCH    = 16;

  // Width of a channel index; a single-channel bank still gets one bit so
  // the cfg_ch port never collapses to zero width.
  function automatic int ch_idx_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // One period-programming request at the default widths.
  typedef struct packed {
    logic [$clog2(DIV_MAX_NCH)-1:0] ch;
    logic [DIV_CNT_W-1:0]           period;
  } div_cfg_t;

endpackage

// File: rtl/divider_channel.sv
// divider_channel: one programmable divider. Holds the running counter, the
// active and shadow periods, the pending-update flag, the registered tick and,
// when DIVIDER_DUTY_OUT_EN is defined, the 50%-duty toggle output.

module divider_channel
  import divider_pkg::*;
#(
  parameter int CNT_W      = DIV_CNT_W,
  parameter int DEF_PERIOD = DIV_DEF_PERIOD
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_period,
  output logic             tick
`ifdef DIVIDER_DUTY_OUT_EN
  ,
  output logic             clkout
`endif
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_PER = CNT_W'(DEF_PERIOD);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] active_q;
  logic [CNT_W-1:0] shadow_q;
  logic             pending_q;
  logic             terminal;
  logic             apply_shadow;

  // Terminal count uses >= so that a period lowered while the channel was
  // disabled (counter held above the new period) ends the current count on
  // the next enabled cycle instead of wrapping through the whole range.
  // A pending shadow is applied at a terminal count, while disabled, or on a
  // phase-align clear; the shadow value seen here is always the one written
  // before this cycle, so a same-cycle write stays pending.
  always_comb begin
    terminal     = en && (count_q >= active_q);
    apply_shadow = pending_q && (sync_clr || !en || terminal);
  end

  // Running counter: restart on clear or terminal count, hold when disabled.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= ONE;
    end else if (sync_clr) begin
      count_q <= ONE;
    end else if (en) begin
      if (terminal) begin
        count_q <= ONE;
      end else begin
        count_q <= count_q + ONE;
      end
    end
  end

  // One-cycle tick at terminal count; a clear suppresses it.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      tick <= 1'b0;
    end else begin
      tick <= terminal && !sync_clr;
    end
  end

  // Active/shadow period pair and the pending flag.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= DEF_PER;
      shadow_q  <= DEF_PER;
      pending_q <= 1'b0;
    end else begin
      if (apply_shadow) begin
        active_q <= shadow_q;
      end
      if (wr_en) begin
        shadow_q <= wr_period;
      end
      pending_q <= wr_en || (pending_q && !apply_shadow);
    end
  end

`ifdef DIVIDER_DUTY_OUT_EN
  // Divided clock: toggles on every tick, forced low by a phase-align clear.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      clkout <= 1'b0;
    end else if (sync_clr) begin
      clkout <= 1'b0;
    end else if (terminal) begin
      clkout <= ~clkout;
    end
  end
`endif

endmodule

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: NCH independent programmable dividers on clkin.
// Validates and decodes period writes, fans out the phase-align clear and
// reports rejected writes on cfg_err. The clkout port and its toggle flops
// exist only when DIVIDER_DUTY_OUT_EN is defined.

module clock_divider_bank
  import divider_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CNT_W      = DIV_CNT_W,
  parameter int DEF_PERIOD = DIV_DEF_PERIOD
) (
  input  logic                      clkin,
  input  logic                      rst_n,
  input  logic [NCH-1:0]            en,
  input  logic                      sync_clr,
  input  logic                      cfg_we,
  input  logic [ch_idx_w(NCH)-1:0]  cfg_ch,
  input  logic [CNT_W-1:0]          cfg_period,
  output logic                      cfg_err,
  output logic [NCH-1:0]            tick
`ifdef DIVIDER_DUTY_OUT_EN
  ,
  output logic [NCH-1:0]            clkout
`endif
);

  localparam int CH_W = ch_idx_w(NCH);

  logic cfg_bad;

  // A write is rejected for a zero period or a channel index past the bank;
  // the index check matters only when NCH is not a power of two.
  always_comb begin
    cfg_bad = (cfg_period == '0) || (32'(cfg_ch) >= 32'(NCH));
  end

  // Registered one-cycle error pulse for each rejected write.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && cfg_bad;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic wr_sel;

    assign wr_sel = cfg_we && !cfg_bad && (cfg_ch == CH_W'(g));

    divider_channel #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_channel (
      .clkin     (clkin),
      .rst_n     (rst_n),
      .en        (en[g]),
      .sync_clr  (sync_clr),
      .wr_en     (wr_sel),
      .wr_period (cfg_period),
      .tick      (tick[g])
`ifdef DIVIDER_DUTY_OUT_EN
      ,
      .clkout    (clkout[g])
`endif
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank: directed bench for clock_divider_bank with four
// channels and a reset period of 5, plus a three-channel instance used to
// exercise the out-of-range channel rejection. clkout checks are compiled in
// only with DIVIDER_DUTY_OUT_EN.

module tb_clock_divider_bank;
  import divider_pkg::*;

  logic        clkin = 1'b0;
  logic        rst_n;
  logic [3:0]  en;
  logic        sync_clr;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_period;
  logic        cfg_err;
  logic [3:0]  tick;

  logic [2:0]  en3;
  logic        cfg3_we;
  logic [1:0]  cfg3_ch;
  logic [31:0] cfg3_period;
  logic        cfg3_err;
  logic [2:0]  tick3;

`ifdef DIVIDER_DUTY_OUT_EN
  logic [3:0]  clkout;
  logic [2:0]  clkout3;
`endif

  int pass_count  = 0;
  int check_count = 0;

  logic [3:0] exp_tick [48] = '{
    4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h2,
    4'h0, 4'hD, 4'h2, 4'h0, 4'h0, 4'h2, 4'hD, 4'h0,
    4'h2, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h2, 4'h0,
    4'hD, 4'h2, 4'h0, 4'h0, 4'h2, 4'h5, 4'h0, 4'h3,
    4'h0, 4'h9, 4'h6, 4'h1, 4'h0, 4'h3, 4'h8, 4'h0,
    4'h8, 4'h8, 4'hA, 4'h8, 4'h9, 4'h8, 4'hE, 4'h8
  };

  clock_divider_bank #(
    .NCH        (4),
    .CNT_W      (32),
    .DEF_PERIOD (5)
  ) dut (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .en         (en),
    .sync_clr   (sync_clr),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_err    (cfg_err),
    .tick       (tick)
`ifdef DIVIDER_DUTY_OUT_EN
    ,
    .clkout     (clkout)
`endif
  );

  clock_divider_bank #(
    .NCH        (3),
    .CNT_W      (32),
    .DEF_PERIOD (5)
  ) dut3 (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .en         (en3),
    .sync_clr   (1'b0),
    .cfg_we     (cfg3_we),
    .cfg_ch     (cfg3_ch),
    .cfg_period (cfg3_period),
    .cfg_err    (cfg3_err),
    .tick       (tick3)
`ifdef DIVIDER_DUTY_OUT_EN
    ,
    .clkout     (clkout3)
`endif
  );

  // Free-running 10 ns system clock.
  always #5 clkin = ~clkin;

  // Drive one cycle of inputs, let one rising edge pass and return at the
  // following falling edge so outputs are sampled away from the active edge.
  task automatic applyStimulus(input logic [3:0] en_v, input logic clr_v,
                               input logic we_v, input div_cfg_t wr);
    en         = en_v;
    sync_clr   = clr_v;
    cfg_we     = we_v;
    cfg_ch     = wr.ch[1:0];
    cfg_period = wr.period;
    @(posedge clkin);
    @(negedge clkin);
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence: reset, programming, error writes, same-cycle update,
  // disable/re-enable, phase-align clear, then reset mid-count.
  initial begin
    logic [3:0] en_v;
    logic       clr_v;
    logic       we_v;
    div_cfg_t   wr;

    rst_n       = 1'b0;
    en          = 4'hF;
    sync_clr    = 1'b0;
    cfg_we      = 1'b0;
    cfg_ch      = 2'd0;
    cfg_period  = 32'd0;
    en3         = 3'b111;
    cfg3_we     = 1'b0;
    cfg3_ch     = 2'd0;
    cfg3_period = 32'd0;

    repeat (3) @(negedge clkin);
    checkOutput("reset tick", 32'(tick), 32'h0);
    checkOutput("reset cfg_err", 32'(cfg_err), 32'h0);
    checkOutput("reset tick3", 32'(tick3), 32'h0);
`ifdef DIVIDER_DUTY_OUT_EN
    checkOutput("reset clkout", 32'(clkout), 32'h0);
`endif
    rst_n = 1'b1;

    for (int c = 1; c <= 48; c++) begin
      en_v        = 4'hF;
      clr_v       = 1'b0;
      we_v        = 1'b0;
      wr          = '0;
      cfg3_we     = 1'b0;
      cfg3_ch     = 2'd0;
      cfg3_period = 32'd0;
      case (c)
        2:  begin we_v = 1'b1; wr = '{ch: 4'd1, period: 32'd3}; end
        16: begin we_v = 1'b1; wr = '{ch: 4'd2, period: 32'd0}; end
        17: begin cfg3_we = 1'b1; cfg3_ch = 2'd3; cfg3_period = 32'd4; end
        18: begin cfg3_we = 1'b1; cfg3_ch = 2'd2; cfg3_period = 32'd4; end
        25: begin we_v = 1'b1; wr = '{ch: 4'd0, period: 32'd2}; end
        28, 29, 30, 31: en_v = 4'h7;
        37: begin we_v = 1'b1; wr = '{ch: 4'd0, period: 32'd5}; end
        38: begin we_v = 1'b1; wr = '{ch: 4'd2, period: 32'd7}; end
        39: begin we_v = 1'b1; wr = '{ch: 4'd3, period: 32'd1}; end
        40: begin clr_v = 1'b1; we_v = 1'b1; wr = '{ch: 4'd1, period: 32'd4}; end
        default: ;
      endcase
      applyStimulus(en_v, clr_v, we_v, wr);
      checkOutput($sformatf("tick@%0d", c), 32'(tick), 32'(exp_tick[c-1]));
      case (c)
        2:  checkOutput("cfg_err valid write", 32'(cfg_err), 32'h0);
        16: checkOutput("cfg_err zero period", 32'(cfg_err), 32'h1);
        17: begin
              checkOutput("cfg_err clears", 32'(cfg_err), 32'h0);
              checkOutput("cfg3_err bad channel", 32'(cfg3_err), 32'h1);
            end
        18: checkOutput("cfg3_err valid write", 32'(cfg3_err), 32'h0);
        default: ;
      endcase
`ifdef DIVIDER_DUTY_OUT_EN
      case (c)
        5:  checkOutput("clkout@5", 32'(clkout), 32'hF);
        8:  checkOutput("clkout@8", 32'(clkout), 32'hD);
        10: checkOutput("clkout@10", 32'(clkout), 32'h0);
        31: checkOutput("clkout3 held", 32'(clkout[3]), 32'h1);
        34: checkOutput("clkout3 resumed", 32'(clkout[3]), 32'h0);
        40: checkOutput("clkout sync_clr", 32'(clkout), 32'h0);
        41: checkOutput("clkout@41", 32'(clkout), 32'h8);
        42: checkOutput("clkout@42", 32'(clkout), 32'h0);
        45: checkOutput("clkout@45", 32'(clkout), 32'hB);
        default: ;
      endcase
`endif
    end

    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset tick", 32'(tick), 32'h0);
    checkOutput("async reset cfg_err", 32'(cfg_err), 32'h0);
`ifdef DIVIDER_DUTY_OUT_EN
    checkOutput("async reset clkout", 32'(clkout), 32'h0);
`endif
    @(negedge clkin);
    rst_n = 1'b1;

    for (int c = 1; c <= 5; c++) begin
      applyStimulus(4'hF, 1'b0, 1'b0, '0);
      checkOutput($sformatf("post-reset tick@%0d", c), 32'(tick),
                  (c == 5) ? 32'hF : 32'h0);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
